// File: rtl/shaft_odometer_pkg.sv
// Shared constants and target FSM encoding for the shaft odometer and its
// downstream drive state machine.
package shaft_odometer_pkg;

    typedef enum logic [1:0] {
        TGT_IDLE  = 2'b00,
        TGT_ARMED = 2'b01,
        TGT_DONE  = 2'b10
    } tgt_state_e;

    // Defaults assume a 50 MHz clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 500;
    localparam int unsigned DEF_SPEED_WINDOW_CYCLES = 5_000_000;
    localparam int unsigned DEF_STALL_WINDOWS       = 3;

    localparam int unsigned ODO_DIST_W  = 16;
    localparam int unsigned ODO_SPEED_W = 8;

endpackage

// File: rtl/shaft_odometer_if.sv
// Pulse-count target command/status bundle between the drive FSM (master)
// and the odometer (slave).
interface shaft_odometer_if
    import shaft_odometer_pkg::*;
#(
    parameter int unsigned DIST_W = ODO_DIST_W
);
    logic              targetValid;
    logic [DIST_W-1:0] targetPulses;
    logic              targetAbort;
    logic              targetBusy;
    logic              targetDone;

    modport master (
        output targetValid, targetPulses, targetAbort,
        input  targetBusy, targetDone
    );

    modport slave (
        input  targetValid, targetPulses, targetAbort,
        output targetBusy, targetDone
    );
endinterface

// File: rtl/shaft_channel.sv
// One wheel: synchroniser, debounce, rising-edge tick, distance, per-window
// speed capture and stall detection.
module shaft_channel
    import shaft_odometer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STALL_WINDOWS   = DEF_STALL_WINDOWS,
    parameter int unsigned DIST_W          = ODO_DIST_W,
    parameter int unsigned SPEED_W         = ODO_SPEED_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_i,
    input  logic               motor_on_i,
    input  logic               clear_dist_i,
    input  logic               win_end_i,
    output logic               tick_o,
    output logic [DIST_W-1:0]  dist_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic               stall_o
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ZC_W = (STALL_WINDOWS > 0) ? $clog2(STALL_WINDOWS + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ZC_W-1:0] STALL_MAX = ZC_W'(STALL_WINDOWS);

    logic [1:0]         sync_q;
    logic [1:0]         seed_q, seed_d;
    logic               deb_q, deb_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               tick_q, rise;
    logic [DIST_W-1:0]  dist_q, dist_d;
    logic [SPEED_W-1:0] win_cnt_q, win_cnt_d, win_total;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [ZC_W-1:0]    zero_cnt_q, zero_cnt_d;

    always_comb begin
        seed_d   = seed_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        // The first valid synchroniser sample after reset is adopted silently,
        // so a level already present at release never counts as a tick.
        if (seed_q != 2'd3) begin
            seed_d = seed_q + 2'd1;
            if (seed_q == 2'd2) deb_d = sync_q[1];
        end else if (sync_q[1] != deb_q) begin
            if (db_cnt_q == DB_LAST) deb_d = sync_q[1];
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
        rise = (seed_q == 2'd3) && !deb_q && deb_d;

        dist_d = dist_q;
        if (clear_dist_i)                dist_d = '0;
        else if (tick_q && dist_q != '1) dist_d = dist_q + 1'b1;

        win_total = (tick_q && win_cnt_q != '1) ? win_cnt_q + 1'b1 : win_cnt_q;
        win_cnt_d = win_end_i ? '0 : win_total;
        speed_d   = win_end_i ? win_total : speed_q;

        zero_cnt_d = zero_cnt_q;
        if (rise || !motor_on_i)
            zero_cnt_d = '0;
        else if (win_end_i && win_total == '0 && zero_cnt_q < STALL_MAX)
            zero_cnt_d = zero_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            seed_q     <= '0;
            deb_q      <= 1'b0;
            db_cnt_q   <= '0;
            tick_q     <= 1'b0;
            dist_q     <= '0;
            win_cnt_q  <= '0;
            speed_q    <= '0;
            zero_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], pulse_i};
            seed_q     <= seed_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            tick_q     <= rise;
            dist_q     <= dist_d;
            win_cnt_q  <= win_cnt_d;
            speed_q    <= speed_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign tick_o  = tick_q;
    assign dist_o  = dist_q;
    assign speed_o = speed_q;
    assign stall_o = (zero_cnt_q >= STALL_MAX);

endmodule

// File: rtl/shaft_odometer.sv
// Dual-wheel shaft odometer: shared speed window, two wheel channels and the
// armed pulse-count target FSM used to time turns and back-ups.
module shaft_odometer
    import shaft_odometer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SPEED_WINDOW_CYCLES = DEF_SPEED_WINDOW_CYCLES,
    parameter int unsigned STALL_WINDOWS       = DEF_STALL_WINDOWS,
    parameter int unsigned DIST_W              = ODO_DIST_W,
    parameter int unsigned SPEED_W             = ODO_SPEED_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shaftPulseL,
    input  logic               shaftPulseR,
    input  logic               motorOn,
    input  logic               clearDist,
    shaft_odometer_if.slave    tgt,
    output logic [DIST_W-1:0]  distL,
    output logic [DIST_W-1:0]  distR,
    output logic [SPEED_W-1:0] speedL,
    output logic [SPEED_W-1:0] speedR,
    output logic               speedValid,
    output logic               stallL,
    output logic               stallR
);
    localparam int unsigned WIN_W = $clog2(SPEED_WINDOW_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SPEED_WINDOW_CYCLES - 1);

    logic [WIN_W-1:0]  win_q;
    logic              win_end;
    logic              valid_q;
    logic              tick_l, tick_r;
    tgt_state_e        state_q, state_d;
    logic [DIST_W-1:0] target_q, target_d;
    logic [DIST_W-1:0] since_l_q, since_l_d;
    logic [DIST_W-1:0] since_r_q, since_r_d;
    logic              busy_q, done_q;

    assign win_end = (win_q == WIN_LAST);

    shaft_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STALL_WINDOWS   (STALL_WINDOWS),
        .DIST_W          (DIST_W),
        .SPEED_W         (SPEED_W)
    ) u_left (
        .clk          (clk),
        .rst          (rst),
        .pulse_i      (shaftPulseL),
        .motor_on_i   (motorOn),
        .clear_dist_i (clearDist),
        .win_end_i    (win_end),
        .tick_o       (tick_l),
        .dist_o       (distL),
        .speed_o      (speedL),
        .stall_o      (stallL)
    );

    shaft_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STALL_WINDOWS   (STALL_WINDOWS),
        .DIST_W          (DIST_W),
        .SPEED_W         (SPEED_W)
    ) u_right (
        .clk          (clk),
        .rst          (rst),
        .pulse_i      (shaftPulseR),
        .motor_on_i   (motorOn),
        .clear_dist_i (clearDist),
        .win_end_i    (win_end),
        .tick_o       (tick_r),
        .dist_o       (distR),
        .speed_o      (speedR),
        .stall_o      (stallR)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        since_l_d = since_l_q;
        since_r_d = since_r_q;
        if (tgt.targetAbort) begin
            state_d = TGT_IDLE;
        end else if (tgt.targetValid) begin
            state_d   = TGT_ARMED;
            target_d  = tgt.targetPulses;
            since_l_d = '0;
            since_r_d = '0;
        end else begin
            unique case (state_q)
                TGT_ARMED: begin
                    if (since_l_q >= target_q && since_r_q >= target_q) state_d = TGT_DONE;
                    if (tick_l && since_l_q != '1) since_l_d = since_l_q + 1'b1;
                    if (tick_r && since_r_q != '1) since_r_d = since_r_q + 1'b1;
                end
                TGT_IDLE, TGT_DONE: ;
                default: state_d = TGT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= '0;
            valid_q   <= 1'b0;
            state_q   <= TGT_IDLE;
            target_q  <= '0;
            since_l_q <= '0;
            since_r_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            win_q     <= win_end ? '0 : win_q + 1'b1;
            valid_q   <= win_end;
            state_q   <= state_d;
            target_q  <= target_d;
            since_l_q <= since_l_d;
            since_r_q <= since_r_d;
            busy_q    <= (state_d == TGT_ARMED);
            done_q    <= (state_d == TGT_DONE);
        end
    end

    assign speedValid     = valid_q;
    assign tgt.targetBusy = busy_q;
    assign tgt.targetDone = done_q;

endmodule

// File: tb/tb_shaft_odometer.sv
// Self-checking bench for shaft_odometer: directed scenarios plus randomized
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_shaft_odometer;
    localparam int unsigned D    = 4;
    localparam int unsigned W    = 100;
    localparam int unsigned S    = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned SW   = 8;
    localparam int unsigned DMAX = (1 << DW) - 1;
    localparam int unsigned SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst, shaftPulseL, shaftPulseR, motorOn, clearDist;
    logic [DW-1:0] distL, distR;
    logic [SW-1:0] speedL, speedR;
    logic          speedValid, stallL, stallR;

    shaft_odometer_if #(.DIST_W(DW)) tif ();

    shaft_odometer #(
        .DEBOUNCE_CYCLES     (D),
        .SPEED_WINDOW_CYCLES (W),
        .STALL_WINDOWS       (S),
        .DIST_W              (DW),
        .SPEED_W             (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .shaftPulseL (shaftPulseL),
        .shaftPulseR (shaftPulseR),
        .motorOn     (motorOn),
        .clearDist   (clearDist),
        .tgt         (tif),
        .distL       (distL),
        .distR       (distR),
        .speedL      (speedL),
        .speedR      (speedR),
        .speedValid  (speedValid),
        .stallL      (stallL),
        .stallR      (stallR)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raw-sample history per wheel, plain integer counters.
    typedef enum {M_IDLE, M_ARMED, M_DONE} mode_t;
    bit          hist [2][D+2];
    bit          m_level [2];
    bit          m_tick [2];
    int unsigned m_dist [2];
    int unsigned m_wcnt [2];
    int unsigned m_speed [2];
    int unsigned m_zero [2];
    int unsigned m_arm [2];
    int unsigned m_since, m_cyc, m_target;
    bit          m_valid;
    mode_t       m_mode;

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < D + 2; k++) hist[w][k] = 1'b0;
            m_level[w] = 0; m_tick[w] = 0; m_dist[w] = 0; m_wcnt[w] = 0;
            m_speed[w] = 0; m_zero[w] = 0; m_arm[w] = 0;
        end
        m_since = 0; m_cyc = 0; m_target = 0; m_valid = 0; m_mode = M_IDLE;
    endtask

    task automatic model_step();
        bit raw [2];
        bit tprev [2];
        bit rise, all_diff, last;
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = shaftPulseL;
        raw[1] = shaftPulseR;
        if (m_since < 4) m_since++;
        last = (m_cyc == W - 1);
        for (int w = 0; w < 2; w++) begin
            tprev[w] = m_tick[w];
            for (int k = D + 1; k > 0; k--) hist[w][k] = hist[w][k-1];
            hist[w][0] = raw[w];
            rise = 0;
            // hist[k] is the raw sample taken k edges ago; the debouncer sees it 2 edges late
            if (m_since == 3) begin
                m_level[w] = hist[w][2];
            end else if (m_since >= 4) begin
                all_diff = 1;
                for (int k = 2; k <= D + 1; k++) if (hist[w][k] == m_level[w]) all_diff = 0;
                if (all_diff) begin
                    m_level[w] = !m_level[w];
                    rise = m_level[w];
                end
            end
            m_tick[w] = rise;
            if (clearDist)                     m_dist[w] = 0;
            else if (tprev[w] && m_dist[w] < DMAX) m_dist[w]++;
            m_wcnt[w] += tprev[w];
            if (rise || !motorOn)                      m_zero[w] = 0;
            else if (last && m_wcnt[w] == 0 && m_zero[w] < S) m_zero[w]++;
            if (last) begin
                m_speed[w] = (m_wcnt[w] > SMAX) ? SMAX : m_wcnt[w];
                m_wcnt[w]  = 0;
            end
        end
        m_valid = last;
        m_cyc   = last ? 0 : m_cyc + 1;
        if (tif.targetAbort) begin
            m_mode = M_IDLE;
        end else if (tif.targetValid) begin
            m_mode = M_ARMED; m_target = tif.targetPulses; m_arm[0] = 0; m_arm[1] = 0;
        end else if (m_mode == M_ARMED) begin
            if (m_arm[0] >= m_target && m_arm[1] >= m_target) m_mode = M_DONE;
            for (int w = 0; w < 2; w++) if (tprev[w] && m_arm[w] < DMAX) m_arm[w]++;
        end
    endtask

    task automatic compare_all();
        check_eq("distL", distL, m_dist[0]);
        check_eq("distR", distR, m_dist[1]);
        check_eq("speedL", speedL, m_speed[0]);
        check_eq("speedR", speedR, m_speed[1]);
        check_eq("speedValid", speedValid, m_valid);
        check_eq("stallL", stallL, m_zero[0] >= S);
        check_eq("stallR", stallR, m_zero[1] >= S);
        check_eq("targetBusy", tif.targetBusy, m_mode == M_ARMED);
        check_eq("targetDone", tif.targetDone, m_mode == M_DONE);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_pulse(input int w, input logic v);
        if (w == 0) shaftPulseL = v;
        else        shaftPulseR = v;
    endtask

    task automatic pulse(input int w, input int hi, input int lo);
        set_pulse(w, 1'b1);
        repeat (hi) step();
        set_pulse(w, 1'b0);
        repeat (lo) step();
    endtask

    task automatic arm(input int unsigned n);
        tif.targetPulses = DW'(n);
        tif.targetValid  = 1'b1;
        step();
        tif.targetValid  = 1'b0;
    endtask

    task automatic wait_speed_valid(output bit found);
        int unsigned n = 0;
        found = 0;
        while (!found && n < 3 * W) begin
            step();
            n++;
            if (speedValid === 1'b1) found = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        int unsigned n;
        int unsigned hold_l, hold_r;
        rst = 1; shaftPulseL = 0; shaftPulseR = 0; motorOn = 0; clearDist = 0;
        tif.targetValid = 0; tif.targetPulses = '0; tif.targetAbort = 0;
        model_reset();
        repeat (3) step();
        check_eq("rst_distL", distL, 0);
        check_eq("rst_speedValid", speedValid, 0);
        check_eq("rst_busy", tif.targetBusy, 0);
        rst = 0;
        repeat (10) step();

        // Clean left pulses and first-tick latency
        shaftPulseL = 1;
        repeat (6) step();
        check_eq("tick_latency_pre", distL, 0);
        step();
        check_eq("tick_latency_post", distL, 1);
        repeat (13) step();
        shaftPulseL = 0;
        repeat (20) step();
        for (int i = 0; i < 9; i++) pulse(0, 20, 20);
        check_eq("clean_distL", distL, 10);
        check_eq("clean_distR", distR, 0);

        // Glitch rejection
        for (int i = 0; i < 3; i++) pulse(1, 3, 10);
        check_eq("glitch_distR", distR, 0);
        pulse(1, 4, 10);
        check_eq("min_pulse_distR", distR, 1);

        // Speed windows
        n = 0;
        while (m_cyc != 0 && n < 2 * W) begin step(); n++; end
        for (int i = 0; i < 5; i++) pulse(1, 6, 6);
        wait_speed_valid(found);
        check_eq("speed_win1_seen", found, 1);
        check_eq("speed_win1_R", speedR, 5);
        check_eq("speed_win1_L", speedL, 0);
        step();
        check_eq("speedValid_one_cycle", speedValid, 0);
        wait_speed_valid(found);
        check_eq("speed_win2_seen", found, 1);
        check_eq("speed_win2_R", speedR, 0);

        // Stall
        motorOn = 1;
        found = 0; n = 0;
        while (!found && n < 4 * W) begin
            step(); n++;
            if (stallL === 1'b1) found = 1;
        end
        check_eq("stall_seen", found, 1);
        check_eq("stall_R_set", stallR, 1);
        shaftPulseL = 1;
        repeat (5) step();
        check_eq("stallL_hold", stallL, 1);
        step();
        check_eq("stallL_clear_on_tick", stallL, 0);
        check_eq("stallR_still", stallR, 1);
        repeat (14) step();
        shaftPulseL = 0;
        repeat (10) step();
        motorOn = 0;
        step();
        check_eq("stallR_motor_off", stallR, 0);
        check_eq("stallL_motor_off", stallL, 0);

        // Target
        arm(3);
        check_eq("tgt_busy_armed", tif.targetBusy, 1);
        for (int i = 0; i < 5; i++) begin
            shaftPulseL = 1;
            shaftPulseR = (i < 2);
            repeat (6) step();
            shaftPulseL = 0;
            shaftPulseR = 0;
            repeat (6) step();
        end
        repeat (4) step();
        check_eq("tgt_busy_hold", tif.targetBusy, 1);
        check_eq("tgt_done_hold", tif.targetDone, 0);
        shaftPulseR = 1;
        repeat (7) step();
        check_eq("tgt_done_pre", tif.targetDone, 0);
        step();
        check_eq("tgt_done", tif.targetDone, 1);
        check_eq("tgt_busy_cleared", tif.targetBusy, 0);
        shaftPulseR = 0;
        repeat (6) step();
        arm(0);
        check_eq("tgt0_busy", tif.targetBusy, 1);
        step();
        check_eq("tgt0_done", tif.targetDone, 1);

        // clearDist coincident with a tick
        shaftPulseL = 1;
        repeat (6) step();
        clearDist = 1;
        step();
        clearDist = 0;
        check_eq("clear_vs_tick", distL, 0);
        repeat (5) step();
        check_eq("clear_tick_lost", distL, 0);
        shaftPulseL = 0;
        repeat (8) step();

        // Abort and re-arm in the same cycle
        tif.targetValid = 1; tif.targetAbort = 1; tif.targetPulses = 4;
        step();
        tif.targetValid = 0; tif.targetAbort = 0;
        check_eq("abort_wins_busy", tif.targetBusy, 0);
        check_eq("abort_wins_done", tif.targetDone, 0);

        // Reset while armed, pulse input high across release
        pulse(1, 6, 6);
        pulse(1, 6, 6);
        arm(5);
        check_eq("pre_rst_busy", tif.targetBusy, 1);
        shaftPulseL = 1;
        rst = 1;
        step();
        check_eq("rst_mid_distR", distR, 0);
        check_eq("rst_mid_busy", tif.targetBusy, 0);
        check_eq("rst_mid_done", tif.targetDone, 0);
        rst = 0;
        repeat (20) step();
        check_eq("no_tick_at_release", distL, 0);
        shaftPulseL = 0;
        repeat (10) step();
        pulse(0, 6, 10);
        check_eq("tick_after_release", distL, 1);

        // Randomized traffic
        hold_l = 1; hold_r = 1; motorOn = 1;
        for (int c = 0; c < 3000; c++) begin
            hold_l--;
            if (hold_l == 0) begin shaftPulseL = ~shaftPulseL; hold_l = $urandom_range(1, 12); end
            hold_r--;
            if (hold_r == 0) begin shaftPulseR = ~shaftPulseR; hold_r = $urandom_range(1, 30); end
            if ($urandom_range(0, 199) == 0) motorOn = ~motorOn;
            clearDist        = ($urandom_range(0, 59) == 0);
            tif.targetValid  = ($urandom_range(0, 39) == 0);
            tif.targetPulses = DW'($urandom_range(0, 6));
            tif.targetAbort  = ($urandom_range(0, 99) == 0);
            rst              = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 0; clearDist = 0; tif.targetValid = 0; tif.targetAbort = 0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shaft_odometer.md
Name: shaft_odometer

Overview:
- Conditions the left/right wheel shaft-encoder pulses (shaftPulseL/shaftPulseR) and produces per-wheel distance, windowed speed and stall flags.
- Provides an armed pulse-count target with a done flag, which the drive state machine uses to time junction turns and back-ups.
- Sits directly upstream of the drive state machine, alongside direction control and tone detection.

Parameters:
DEBOUNCE_CYCLES, 500, consecutive clk cycles a synchronised input must differ from the debounced level before the new level is accepted (10 us at 50 MHz)
SPEED_WINDOW_CYCLES, 5_000_000, length of the speed measurement window in clk cycles (100 ms)
STALL_WINDOWS, 3, consecutive zero-tick windows while motorOn is high before stall asserts
DIST_W, 16, width of the distance and target counters
SPEED_W, 8, width of the speed outputs

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
shaftPulseL  in  1  raw left encoder, asynchronous
shaftPulseR  in  1  raw right encoder, asynchronous
motorOn  in  1  high while the H-bridge enables are driven; gates stall detection
clearDist  in  1  one-cycle pulse; zeroes distL/distR
targetValid  in  1  one-cycle pulse; arms the target with targetPulses
targetPulses  in  DIST_W  ticks both wheels must travel after arming
targetAbort  in  1  one-cycle pulse; returns the target FSM to IDLE
distL, distR  out  DIST_W  rising-edge ticks since reset/clear, saturating
speedL, speedR  out  SPEED_W  ticks counted in the last completed window, saturating
speedValid  out  1  one-cycle strobe when speedL/R update
stallL, stallR  out  1  wheel stalled while motorOn
targetBusy  out  1  target armed, not yet reached
targetDone  out  1  level; target reached, held until re-arm/abort/reset

Behaviour:
- Reset (rst=1 at posedge): every output is 0; the synchroniser, debounced level and all counters are 0; target FSM in IDLE; window counter is 0.
- Synchroniser: two flops per wheel. The debounce counter increments each cycle the sync output differs from the debounced level and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the sync value and the counter clears.
- Tick: a one-cycle internal pulse, registered in the same cycle the debounced level goes 0->1. Falling edges produce no tick.
- Tick latency: DEBOUNCE_CYCLES+2 clk cycles from raw edge to tick. Glitches shorter than DEBOUNCE_CYCLES cycles produce no tick.
- Distance: distX increments the cycle after a tick and saturates at 2^DIST_W-1. clearDist has priority over a simultaneous tick, and that tick is lost.
- Speed window: a free-running counter counts 0..SPEED_WINDOW_CYCLES-1.
  - In the last cycle of the window, speedX takes the tick count of the closing window, including a tick in that same cycle. The count saturates at 2^SPEED_W-1.
  - speedValid pulses for that one cycle, and the per-window tick counters restart at 0.
- Stall:
  - A per-wheel zero-window counter increments at each window end with a zero count while motorOn=1.
  - It clears on any tick, or on any cycle with motorOn=0.
  - stallX=1 while the counter is >= STALL_WINDOWS. The counter saturates there.
- Target FSM, states IDLE, ARMED, DONE:
  - IDLE: targetValid -> ARMED; latch targetPulses and zero both since-arm counters.
  - ARMED:
    - The since-arm counters increment on ticks and saturate.
    - When both counters are >= the latched target, go to DONE on the next edge.
    - A target of 0 reaches DONE one cycle after arming.
    - targetValid re-arms: latch the new target and zero the counters. A tick in that same cycle is not counted.
    - targetAbort -> IDLE.
  - DONE: targetDone=1. targetValid -> ARMED; targetAbort -> IDLE.
  - Priority when pulses coincide: rst > targetAbort > targetValid > completion.
- targetBusy=1 exactly in ARMED; targetDone=1 exactly in DONE. Both are registered state decodes.
- clearDist does not affect the since-arm counters or speed/stall state.
- Reset mid-operation: all state returns to reset values on the next edge. A pulse input level at release produces no tick unless it later transitions.

Decomposition:
- Shared package: target FSM state encoding (IDLE=2'b00, ARMED=2'b01, DONE=2'b10), the default timing constants, and the width constants used by the drive state machine.
- Sub-module shaft_channel, instantiated twice: sync, debounce, tick, distance, window count, speed latch and stall counter for one wheel.
- The top level holds the window counter (shared, so both wheels' speed updates are aligned) and the target FSM.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, SPEED_WINDOW_CYCLES=100, STALL_WINDOWS=2):
- Clean pulses: 10 left pulses, each 20 cycles high / 20 low -> distL=10, distR=0. First tick occurs 6 cycles after the first raw rise.
- Glitch rejection: 3-cycle high pulses on shaftPulseR -> distR stays 0. A 4-cycle pulse -> distR=1.
- Speed: 5 right pulses inside window 1 -> at cycle 99, speedValid=1 for one cycle and speedR=5, speedL=0. Window 2 with no pulses -> speedR=0.
- Stall: motorOn=1, no pulses for 2 windows -> stallL=stallR=1 after the second window end. One left pulse -> stallL=0 six cycles after the raw edge. motorOn=0 -> both clear next cycle.
- Target: arm with targetPulses=3, then drive L with 5 pulses and R with 2 -> targetBusy holds. A 3rd R tick -> DONE one cycle later. targetPulses=0 -> targetDone=1 one cycle after arming.
- Collisions and reset: clearDist coincident with a tick -> distX=0. targetAbort and targetValid in the same cycle -> IDLE. rst while ARMED -> all outputs 0 on the next edge.
